// File: rtl/spi_mnrch_if.sv
// SPI monarch (master) bus bundle: host handshake plus the four SPI wires.
// Optional busy flag exists only when SPI_MNRCH_BUSY_EN is defined.
interface spi_mnrch_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
`ifdef SPI_MNRCH_BUSY_EN
    logic        busy;
`endif

    // SPI master side (the DUT)
    modport master (
        input  wrt,
        input  wt_data,
        input  MISO,
        output done,
        output rd_data,
        output SS_n,
        output SCLK,
`ifdef SPI_MNRCH_BUSY_EN
        output busy,
`endif
        output MOSI
    );

    // Host plus peripheral side
    modport slave (
        output wrt,
        output wt_data,
        output MISO,
        input  done,
        input  rd_data,
        input  SS_n,
        input  SCLK,
`ifdef SPI_MNRCH_BUSY_EN
        input  busy,
`endif
        input  MOSI
    );
endinterface

// File: rtl/spi_mnrch.sv
// SPI mode-3 master performing 16-bit full-duplex transactions, MSB first.
// SCLK is the MSB of a free-running divider counter; SCLK period = 2^SCLK_DIV_W clks.
// Optional feature: define SPI_MNRCH_BUSY_EN to add the busy output on the bus.
module spi_mnrch #(
    parameter int unsigned SCLK_DIV_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    spi_mnrch_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StBackPorch
    } state_e;

    localparam logic [SCLK_DIV_W-1:0] CntAllOnes = '1;
    // Four clocks after load the counter reaches all-ones; the next edge is the first fall.
    localparam logic [SCLK_DIV_W-1:0] CntLoad    = CntAllOnes - SCLK_DIV_W'(4);
    // Last cycle with SCLK low: MISO is captured here, SCLK rises on the next edge.
    localparam logic [SCLK_DIV_W-1:0] CntSample  = CntAllOnes >> 1;

    state_e                state_q, state_d;
    logic [SCLK_DIV_W-1:0] cnt_q, cnt_d;
    logic [15:0]           shreg_q, shreg_d;
    logic                  miso_q, miso_d;
    logic [4:0]            smp_q, smp_d;
    logic                  ss_n_q, ss_n_d;
    logic                  done_q, done_d;

    // State and datapath registers; the divider resets to its idle value so SCLK sits high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= CntLoad;
            shreg_q <= '0;
            miso_q  <= 1'b0;
            smp_q   <= '0;
            ss_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            miso_q  <= miso_d;
            smp_q   <= smp_d;
            ss_n_q  <= ss_n_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load on wrt, sample before each rise, shift on each fall after the first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        miso_d  = miso_q;
        smp_d   = smp_q;
        ss_n_d  = ss_n_q;
        done_d  = done_q;

        if (state_q != StIdle) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (bus.wrt) begin
                    shreg_d = bus.wt_data;
                    cnt_d   = CntLoad;
                    smp_d   = '0;
                    ss_n_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == CntSample) begin
                    miso_d = bus.MISO;
                    smp_d  = smp_q + 5'd1;
                    if (smp_q == 5'd15) begin
                        state_d = StBackPorch;
                    end
                end
                // The first fall is a front porch: nothing has been sampled yet.
                if (cnt_q == CntAllOnes && smp_q != 5'd0) begin
                    shreg_d = {shreg_q[14:0], miso_q};
                end
            end
            StBackPorch: begin
                if (cnt_q == CntAllOnes) begin
                    shreg_d = {shreg_q[14:0], miso_q};
                    // Reload instead of wrapping so the trailing fall never appears.
                    cnt_d   = CntLoad;
                    done_d  = 1'b1;
                    ss_n_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.SCLK    = cnt_q[SCLK_DIV_W-1];
    assign bus.MOSI    = shreg_q[15];
    assign bus.rd_data = shreg_q;
    assign bus.SS_n    = ss_n_q;
    assign bus.done    = done_q;
`ifdef SPI_MNRCH_BUSY_EN
    // Non-idle exactly matches the SS_n-low window.
    assign bus.busy    = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_spi_mnrch.sv
// Bench for spi_mnrch with a small mode-3 inertial-sensor style peripheral model.
module tb_spi_mnrch;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   sclk_rises = 0;

    spi_mnrch_if bus ();

    spi_mnrch #(
        .SCLK_DIV_W(4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge bus.SCLK) sclk_rises++;

    // ---------------- peripheral model ----------------
    logic [7:0]  reg_0d = 8'h00;
    logic        miso_m = 1'b0;
    logic        sclk_prev = 1'b1;
    int          s_cnt = 0;
    logic [15:0] s_rx = '0;
    logic [6:0]  s_addr = '0;
    logic        s_rd = 1'b0;
    logic [7:0]  s_byte;

    assign bus.MISO = miso_m;

    function automatic logic [7:0] model_reg(input logic [6:0] a);
        case (a)
            7'h0F:   return 8'h6A;
            7'h25:   return 8'h7B;
            7'h24:   return 8'h0D;
            7'h22:   return 8'h63;
            7'h2A:   return 8'h12;
            7'h27:   return 8'hCD;
            7'h29:   return 8'h57;
            7'h0D:   return reg_0d;
            default: return 8'h00;
        endcase
    endfunction

    always @(bus.SCLK or bus.SS_n) begin
        if (bus.SS_n !== 1'b0) begin
            s_cnt  = 0;
            s_rx   = '0;
            s_rd   = 1'b0;
            miso_m = 1'b0;
        end else if (bus.SCLK === 1'b1 && sclk_prev === 1'b0) begin
            s_rx = {s_rx[14:0], bus.MOSI};
            s_cnt++;
            if (s_cnt == 8) begin
                s_rd   = s_rx[7];
                s_addr = s_rx[6:0];
            end
            if (s_cnt == 16 && !s_rx[15] && s_rx[14:8] == 7'h0D) reg_0d = s_rx[7:0];
        end else if (bus.SCLK === 1'b0 && sclk_prev === 1'b1) begin
            if (s_rd && s_cnt >= 8 && s_cnt < 16) begin
                s_byte = model_reg(s_addr);
                miso_m = s_byte[15 - s_cnt];
            end else begin
                miso_m = 1'b0;
            end
        end
        sclk_prev = bus.SCLK;
    end

    // ---------------- helpers ----------------
    // Called at posedge+1; returns at posedge+1 after done rises or the budget expires.
    task automatic xfer(input logic [15:0] w, output logic [15:0] rd, output int lat);
        bus.wt_data = w;
        bus.wrt     = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = bus.rd_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n       = 1'b0;
        bus.wrt     = 1'b0;
        bus.wt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.SS_n !== 1'b1) begin n_err++; $display("FAIL reset_ss_n: got %b want 1", bus.SS_n); end
        n_cmp++; if (bus.SCLK !== 1'b1) begin n_err++; $display("FAIL reset_sclk: got %b want 1", bus.SCLK); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.MOSI !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", bus.MOSI); end
        n_cmp++; if (bus.rd_data !== 16'h0000) begin n_err++; $display("FAIL reset_rd_data: got %h want 0000", bus.rd_data); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_who_am_i();
        logic [15:0] rd;
        int lat;
        int bad;
        sclk_rises = 0;
        xfer(16'h8F00, rd, lat);
        n_cmp++; if (lat != 261) begin n_err++; $display("FAIL whoami_latency: got %0d want 261", lat); end
        n_cmp++; if (rd !== 16'h006A) begin n_err++; $display("FAIL whoami_rd_data: got %h want 006A", rd); end
        n_cmp++; if (sclk_rises != 16) begin n_err++; $display("FAIL whoami_sclk_rises: got %0d want 16", sclk_rises); end
        n_cmp++; if (bus.SS_n !== 1'b1) begin n_err++; $display("FAIL whoami_ss_n: got %b want 1", bus.SS_n); end
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1 if (bus.SCLK !== 1'b1 || bus.done !== 1'b1 || bus.rd_data !== 16'h006A) bad++;
        end
        n_cmp++; if (bad != 0 || sclk_rises != 16) begin
            n_err++; $display("FAIL whoami_idle_hold: got %0d bad cycles, %0d rises want 0, 16", bad, sclk_rises);
        end
    endtask

    task automatic test_write();
        logic [15:0] rd;
        int lat;
        xfer(16'h0D02, rd, lat);
        n_cmp++; if (lat != 261) begin n_err++; $display("FAIL write_latency: got %0d want 261", lat); end
        n_cmp++; if (reg_0d !== 8'h02) begin n_err++; $display("FAIL write_model_reg: got %h want 02", reg_0d); end
        xfer(16'h8D00, rd, lat);
        n_cmp++; if (rd !== 16'h0002) begin n_err++; $display("FAIL write_readback: got %h want 0002", rd); end
    endtask

    // Back-to-back reads: each wrt lands on the cycle right after the previous done.
    task automatic test_back_to_back();
        logic [15:0] cmd [7] = '{16'hA500, 16'hA400, 16'hA200, 16'hAA00, 16'hA700, 16'hA200, 16'hA900};
        logic [7:0]  exp [7] = '{8'h7B, 8'h0D, 8'h63, 8'h12, 8'hCD, 8'h63, 8'h57};
        logic [15:0] rd;
        int lat;
        for (int i = 0; i < 7; i++) begin
            xfer(cmd[i], rd, lat);
            n_cmp++; if (rd !== {8'h00, exp[i]} || lat != 261) begin
                n_err++; $display("FAIL b2b_read_%0d: got %h lat %0d want %h lat 261", i, rd, lat, {8'h00, exp[i]});
            end
        end
    endtask

    task automatic test_wrt_ignored();
        int lat;
        sclk_rises  = 0;
        bus.wt_data = 16'h8F00;
        bus.wrt     = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
        repeat (50) @(posedge clk);
        #1 bus.wt_data = 16'hA500;
        bus.wrt = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
        bus.wt_data = '0;
        lat = 51;
        while (bus.done !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
        n_cmp++; if (lat != 261) begin n_err++; $display("FAIL ignore_latency: got %0d want 261", lat); end
        n_cmp++; if (bus.rd_data !== 16'h006A) begin n_err++; $display("FAIL ignore_rd_data: got %h want 006A", bus.rd_data); end
        n_cmp++; if (sclk_rises != 16) begin n_err++; $display("FAIL ignore_sclk_rises: got %0d want 16", sclk_rises); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] rd;
        int lat;
        int bad;
        bus.wt_data = 16'hA500;
        bus.wrt     = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
        // 90 edges in SCLK is low, so the reset must force it high.
        repeat (89) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.SS_n !== 1'b1) begin n_err++; $display("FAIL abort_ss_n: got %b want 1", bus.SS_n); end
        n_cmp++; if (bus.SCLK !== 1'b1) begin n_err++; $display("FAIL abort_sclk: got %b want 1", bus.SCLK); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.rd_data !== 16'h0000) begin n_err++; $display("FAIL abort_rd_data: got %h want 0000", bus.rd_data); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(posedge clk);
            #1 if (bus.done !== 1'b0 || bus.SS_n !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL abort_no_done: got %0d bad cycles want 0", bad); end
        xfer(16'hA500, rd, lat);
        n_cmp++; if (rd !== 16'h007B || lat != 261) begin
            n_err++; $display("FAIL abort_recover: got %h lat %0d want 007B lat 261", rd, lat);
        end
    endtask

`ifdef SPI_MNRCH_BUSY_EN
    task automatic test_busy();
        int bad;
        int n;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", bus.busy); end
        bus.wt_data = 16'h8F00;
        bus.wrt     = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_start: got %b want 1", bus.busy); end
        bad = 0;
        n   = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1 n++;
            if (bus.busy !== ~bus.SS_n) bad++;
        end
        n_cmp++; if (bad != 0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL busy_tracks_ss_n: got %0d bad cycles, busy %b want 0, 0", bad, bus.busy);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_who_am_i();
        test_write();
        test_back_to_back();
        test_wrt_ignored();
        test_reset_abort();
`ifdef SPI_MNRCH_BUSY_EN
        test_busy();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
